// File: rtl/usb_ep0_ctrl.sv
// Control endpoint 0 sequencer: token/data/handshake FSM, device address and configuration.
// SET_ADDRESS / SET_CONFIGURATION are committed only once the host ACKs the status stage.
module usb_ep0_ctrl #(
    parameter int TIMEOUT_CYCLES = 96,
    parameter int TMR_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        usb_rst,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    output logic        tx_req,
    output logic [3:0]  tx_pid,
    input  logic        tx_done,
    output logic [6:0]  dev_addr,
    output logic [1:0]  dev_state,
    output logic        cfg_value,
    output logic        busy
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] DEV_DEFAULT    = 2'd0;
    localparam logic [1:0] DEV_ADDRESS    = 2'd1;
    localparam logic [1:0] DEV_CONFIGURED = 2'd2;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA_WAIT, TX, ACK_WAIT} state_t;
    typedef enum logic {KIND_ADDR, KIND_CFG} kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic             is_setup_q, is_setup_d;
    logic [3:0]       endp_q, endp_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             status_pending_q, status_pending_d;
    logic             stall_ep0_q, stall_ep0_d;
    logic [6:0]       pending_addr_q, pending_addr_d;
    logic             pending_cfg_q, pending_cfg_d;
    logic             tx_req_q, tx_req_d;
    logic [3:0]       tx_pid_q, tx_pid_d;
    logic [6:0]       dev_addr_q, dev_addr_d;
    logic [1:0]       dev_state_q, dev_state_d;
    logic             cfg_value_q, cfg_value_d;
    logic             busy_q, busy_d;

    logic        rx_ok;
    logic        token_ok;
    logic        timed_out;
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic        unused_rx_data;

    assign rx_ok           = rx_valid & ~rx_error;
    assign token_ok        = rx_ok && (rx_pid == PID_SETUP || rx_pid == PID_OUT || rx_pid == PID_IN)
                             && (rx_addr == dev_addr_q);
    assign timed_out       = (timer_q == TMR_LAST);
    assign bm_request_type = rx_data[7:0];
    assign b_request       = rx_data[15:8];
    assign w_value         = rx_data[31:16];
    assign unused_rx_data  = ^rx_data[63:32];

    // Bus reset is synchronous and overrides everything else in the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            kind_q           <= KIND_ADDR;
            is_setup_q       <= 1'b0;
            endp_q           <= 4'd0;
            timer_q          <= '0;
            status_pending_q <= 1'b0;
            stall_ep0_q      <= 1'b0;
            pending_addr_q   <= 7'd0;
            pending_cfg_q    <= 1'b0;
            tx_req_q         <= 1'b0;
            tx_pid_q         <= PID_ACK;
            dev_addr_q       <= 7'd0;
            dev_state_q      <= DEV_DEFAULT;
            cfg_value_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else if (usb_rst) begin
            state_q          <= IDLE;
            kind_q           <= KIND_ADDR;
            is_setup_q       <= 1'b0;
            endp_q           <= 4'd0;
            timer_q          <= '0;
            status_pending_q <= 1'b0;
            stall_ep0_q      <= 1'b0;
            pending_addr_q   <= 7'd0;
            pending_cfg_q    <= 1'b0;
            tx_req_q         <= 1'b0;
            tx_pid_q         <= PID_ACK;
            dev_addr_q       <= 7'd0;
            dev_state_q      <= DEV_DEFAULT;
            cfg_value_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            is_setup_q       <= is_setup_d;
            endp_q           <= endp_d;
            timer_q          <= timer_d;
            status_pending_q <= status_pending_d;
            stall_ep0_q      <= stall_ep0_d;
            pending_addr_q   <= pending_addr_d;
            pending_cfg_q    <= pending_cfg_d;
            tx_req_q         <= tx_req_d;
            tx_pid_q         <= tx_pid_d;
            dev_addr_q       <= dev_addr_d;
            dev_state_q      <= dev_state_d;
            cfg_value_q      <= cfg_value_d;
            busy_q           <= busy_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        is_setup_d       = is_setup_q;
        endp_d           = endp_q;
        timer_d          = timer_q;
        status_pending_d = status_pending_q;
        stall_ep0_d      = stall_ep0_q;
        pending_addr_d   = pending_addr_q;
        pending_cfg_d    = pending_cfg_q;
        tx_pid_d         = tx_pid_q;
        dev_addr_d       = dev_addr_q;
        dev_state_d      = dev_state_q;
        cfg_value_d      = cfg_value_q;

        case (state_q)
            IDLE: begin
                if (token_ok) begin
                    if (rx_pid == PID_IN) begin
                        state_d = TX;
                        if (rx_endp != 4'd0 || stall_ep0_q) begin
                            tx_pid_d = PID_STALL;
                        end else if (status_pending_q) begin
                            tx_pid_d = PID_DATA1;
                        end else begin
                            tx_pid_d = PID_NAK;
                        end
                    end else begin
                        state_d    = DATA_WAIT;
                        is_setup_d = (rx_pid == PID_SETUP);
                        endp_d     = rx_endp;
                        timer_d    = '0;
                    end
                end
            end

            DATA_WAIT: begin
                if (rx_ok && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
                    state_d = TX;
                    if (is_setup_q) begin
                        // A new SETUP always wins: it cancels any stall and any unacknowledged request.
                        tx_pid_d         = PID_ACK;
                        stall_ep0_d      = 1'b0;
                        status_pending_d = 1'b0;
                        if (bm_request_type == 8'h00 && b_request == 8'h05
                            && dev_state_q != DEV_CONFIGURED) begin
                            pending_addr_d   = w_value[6:0];
                            status_pending_d = 1'b1;
                            kind_d           = KIND_ADDR;
                        end else if (bm_request_type == 8'h00 && b_request == 8'h09
                                     && dev_state_q != DEV_DEFAULT && w_value <= 16'd1) begin
                            pending_cfg_d    = w_value[0];
                            status_pending_d = 1'b1;
                            kind_d           = KIND_CFG;
                        end else begin
                            stall_ep0_d = 1'b1;
                        end
                    end else if (endp_q != 4'd0 || stall_ep0_q) begin
                        tx_pid_d = PID_STALL;
                    end else begin
                        tx_pid_d = PID_ACK;
                    end
                end else if (rx_valid || timed_out) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            TX: begin
                if (tx_done) begin
                    state_d = (tx_pid_q == PID_DATA1) ? ACK_WAIT : IDLE;
                    timer_d = '0;
                end
            end

            ACK_WAIT: begin
                if (rx_ok && rx_pid == PID_ACK) begin
                    state_d          = IDLE;
                    status_pending_d = 1'b0;
                    if (kind_q == KIND_ADDR) begin
                        dev_addr_d  = pending_addr_q;
                        dev_state_d = (pending_addr_q != 7'd0) ? DEV_ADDRESS : DEV_DEFAULT;
                    end else begin
                        cfg_value_d = pending_cfg_q;
                        dev_state_d = pending_cfg_q ? DEV_CONFIGURED : DEV_ADDRESS;
                    end
                end else if (rx_valid || timed_out) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        tx_req_d = (state_d == TX);
        busy_d   = (state_d != IDLE);
    end

    assign tx_req    = tx_req_q;
    assign tx_pid    = tx_pid_q;
    assign dev_addr  = dev_addr_q;
    assign dev_state = dev_state_q;
    assign cfg_value = cfg_value_q;
    assign busy      = busy_q;

endmodule

// File: doc/usb_ep0_ctrl.md
Name: usb_ep0_ctrl

Overview:
Control-endpoint sequencer for the USB hub. It consumes decoded packets from the downstream SIE (pulse, PID, address, endpoint, 64-bit data), runs the token/data/handshake transaction FSM and requests handshake or zero-length data packets from the transmitter. It owns the device state and hub address, and applies SET_ADDRESS and SET_CONFIGURATION only after the status stage has been ACKed.

Parameters:
TIMEOUT_CYCLES, 96, clk cycles to wait for a follow-up packet (data or ACK) before abandoning the transaction
TMR_W, 8, timer width; must satisfy TIMEOUT_CYCLES < 2**TMR_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
usb_rst  input  1  synchronous USB bus-reset pulse (SE0 timeout); returns all state to reset values
rx_valid  input  1  one-cycle pulse: SIE end_transmission, packet fields valid this cycle
rx_error  input  1  qualifies rx_valid; packet corrupt (CRC/PID/bitstuff)
rx_pid  input  4  received pid_t
rx_addr  input  7  token address field
rx_endp  input  4  token endpoint field
rx_data  input  64  data payload; byte0 = rx_data[7:0]
tx_req  output  1  request transmission; held until tx_done
tx_pid  output  4  pid_t to send (ACK, NAK, STALL, or zero-length DATA1)
tx_done  input  1  one-cycle pulse: transmitter finished the packet
dev_addr  output  7  current device address
dev_state  output  2  0 DEFAULT, 1 ADDRESS, 2 CONFIGURED
cfg_value  output  1  active configuration value (0/1)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_n low, or usb_rst high at a clock edge): tx_req=0, tx_pid=ACK, dev_addr=0, dev_state=DEFAULT, cfg_value=0, busy=0, FSM=IDLE, the status_pending/stall_ep0/timer registers cleared. usb_rst has priority over every other event in the same cycle.
- Accepted token: rx_valid & ~rx_error & PID in {SETUP, OUT, IN} & rx_addr==dev_addr. All other packets in IDLE are ignored, SOF included.
- FSM states: IDLE, DATA_WAIT, TX, ACK_WAIT.
- IDLE, SETUP/OUT token -> DATA_WAIT. Latch is_setup and endp; clear the timer.
- IDLE, IN token, endp!=0 or stall_ep0 -> TX with STALL.
- IDLE, IN token, endp 0 with status_pending -> TX with DATA1 (zero-length status); TX then exits to ACK_WAIT.
- IDLE, IN token, any other case -> TX with NAK.
- DATA_WAIT: timer increments each cycle. Exit paths:
  - rx_valid & ~rx_error & PID DATA0/DATA1 -> TX. Reply is STALL if this is an OUT with endp!=0 or with stall_ep0 set; otherwise ACK.
  - rx_error, any other PID, or timer==TIMEOUT_CYCLES-1 -> IDLE with no response. A SETUP abandoned this way leaves stall_ep0 and status_pending unchanged.
- SETUP data always gets ACK; it clears stall_ep0 and status_pending, then decodes bmRequestType=rx_data[7:0], bRequest=rx_data[15:8], wValue=rx_data[31:16]:
  - 0x00/0x05 SET_ADDRESS, dev_state!=CONFIGURED: pending_addr=wValue[6:0], status_pending=1, kind=ADDR.
  - 0x00/0x09 SET_CONFIGURATION, dev_state!=DEFAULT, wValue<=1: pending_cfg=wValue[0], status_pending=1, kind=CFG.
  - Anything else: stall_ep0=1.
- TX: tx_req=1 and tx_pid stable from the cycle the state is entered until the cycle tx_done is seen. On tx_done, tx_req drops the next cycle. Next state is ACK_WAIT if DATA1 was sent, else IDLE. rx_valid during TX is ignored.
- ACK_WAIT: timer as in DATA_WAIT. Exit paths:
  - rx_valid & ~rx_error & PID ACK -> apply the pending request, clear status_pending, go IDLE.
    - ADDR: dev_addr=pending_addr; dev_state = ADDRESS if the address is nonzero, else DEFAULT.
    - CFG: cfg_value=pending_cfg; dev_state = CONFIGURED if the value is 1, else ADDRESS.
  - Timeout, error or other PID -> IDLE with status_pending kept, so a host retry of the IN re-sends DATA1.
- Address change takes effect the cycle after the ACK. The status IN is matched against the old address.
- busy = (FSM != IDLE), registered.

Test Plan:
- Reset then idle: dev_addr=0, dev_state=0, tx_req=0. IN addr 0 endp 0 -> tx_pid=NAK, tx_req held until tx_done, then IDLE.
- SETUP addr0 + DATA0 {00,05,0x12,00..} -> ACK. IN addr0 ep0 -> DATA1. Host ACK -> dev_addr=0x12, dev_state=1. Next token to addr 0 is ignored (no tx_req).
- Same sequence with status ACK withheld past TIMEOUT_CYCLES -> dev_addr stays 0. Repeated IN -> DATA1 again; ACK -> address applied.
- At addr 0x12: SETUP + DATA0 {00,09,01,00} then status IN/ACK -> dev_state=2, cfg_value=1. Then SET_ADDRESS -> SETUP ACKed, the next IN ep0 gets STALL. A new valid SETUP clears the stall.
- SETUP followed by rx_error packet -> no tx_req, IDLE. IN to endp 3 -> STALL.
- usb_rst pulsed mid-TX (tx_req=1) and again in the same cycle as rx_valid -> next cycle all outputs at reset values, the token is ignored.
